// File: rtl/uart_result_fmt_pkg.sv
// Shared definitions for the calculator result formatter: state encoding,
// ASCII constants and the decimal weight table.
package uart_result_fmt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int FRAME_TICKS_DEF = 11;

    function automatic logic [15:0] weight(input logic [2:0] k);
        case (k)
            3'd0:    weight = 16'd10000;
            3'd1:    weight = 16'd1000;
            3'd2:    weight = 16'd100;
            3'd3:    weight = 16'd10;
            default: weight = 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_result_fmt_if.sv
// Result input and transmitter-side signals of the formatter.
// master = upstream / transmitter side, slave = formatter.
interface uart_result_fmt_if;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_err;
    logic        res_ready;
    logic        txen;
    logic [7:0]  tx_data;
    logic        valid;
    logic        busy;

    modport master (
        output res_valid, res_data, res_err, txen,
        input  res_ready, tx_data, valid, busy
    );

    modport slave (
        input  res_valid, res_data, res_err, txen,
        output res_ready, tx_data, valid, busy
    );
endinterface

// File: rtl/uart_result_fmt_bin2dec_seq.sv
// Sequential binary-to-decimal converter by repeated subtraction, one
// compare per cycle, with leading-zero suppression (units digit always sent).
module bin2dec_seq
    import uart_result_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] mag,
    output logic        dig_vld,
    output logic [7:0]  dig_ascii,
    output logic        done
);

    logic [15:0] rem;
    logic [2:0]  k;
    logic [3:0]  digit;
    logic        seen;
    logic        active;
    logic [15:0] w;

    assign w = weight(k);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rem       <= '0;
            k         <= '0;
            digit     <= '0;
            seen      <= 1'b0;
            active    <= 1'b0;
            dig_vld   <= 1'b0;
            dig_ascii <= '0;
            done      <= 1'b0;
        end else begin
            dig_vld <= 1'b0;
            done    <= 1'b0;
            if (start) begin
                rem    <= mag;
                k      <= '0;
                digit  <= '0;
                seen   <= 1'b0;
                active <= 1'b1;
            end else if (active) begin
                if (rem >= w) begin
                    rem   <= rem - w;
                    digit <= digit + 4'd1;
                end else begin
                    if (digit != 4'd0 || seen || k == 3'd4) begin
                        dig_vld   <= 1'b1;
                        dig_ascii <= ASC_ZERO + {4'd0, digit};
                    end
                    if (digit != 4'd0) seen <= 1'b1;
                    digit <= '0;
                    if (k == 3'd4) begin
                        k      <= '0;
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_result_fmt.sv
// Formats a signed 16-bit result (or error) as decimal ASCII and paces the
// characters to the UART transmitter by counting its baud ticks.
module uart_result_fmt
    import uart_result_fmt_pkg::*;
#(
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter bit EOL_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            n_rst,
    uart_result_fmt_if.slave bus
);

    localparam logic [3:0] FT = 4'(FRAME_TICKS);

    state_t      state;
    logic [7:0]  chars [8];
    logic [3:0]  len;
    logic [3:0]  idx;
    logic [3:0]  tick_cnt;
    logic        valid_q;
    logic [7:0]  tx_q;

    logic        neg;
    logic [15:0] mag;
    logic        start;
    logic        dig_vld;
    logic [7:0]  dig_ascii;
    logic        done;
    logic [3:0]  base;
    logic [3:0]  idx_nx;
    logic [7:0]  first_ch;

    assign neg    = bus.res_data[15] & ~bus.res_err;
    assign mag    = neg ? (~bus.res_data + 16'd1) : bus.res_data;
    assign start  = (state == S_IDLE) && bus.res_valid && !bus.res_err;
    assign base   = len + {3'd0, dig_vld};
    assign idx_nx = idx + 4'd1;
    // The units digit lands in the same cycle as done, so an unsigned result
    // has not reached the buffer yet when the first character is launched.
    assign first_ch = (len == 4'd0) ? dig_ascii : chars[0];

    bin2dec_seq u_conv (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .mag       (mag),
        .dig_vld   (dig_vld),
        .dig_ascii (dig_ascii),
        .done      (done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            len      <= '0;
            idx      <= '0;
            tick_cnt <= '0;
            valid_q  <= 1'b0;
            tx_q     <= '0;
            for (int i = 0; i < 8; i++) chars[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.res_valid) begin
                    for (int i = 0; i < 8; i++) chars[i] <= '0;
                    idx      <= '0;
                    tick_cnt <= '0;
                    if (bus.res_err) begin
                        chars[0] <= ASC_E;
                        chars[1] <= ASC_R;
                        chars[2] <= ASC_R;
                        if (EOL_EN) begin
                            chars[3] <= ASC_CR;
                            chars[4] <= ASC_LF;
                            len      <= 4'd5;
                        end else begin
                            len <= 4'd3;
                        end
                        valid_q <= 1'b1;
                        tx_q    <= ASC_E;
                        state   <= S_SEND;
                    end else begin
                        if (neg) chars[0] <= ASC_MINUS;
                        len   <= neg ? 4'd1 : 4'd0;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (dig_vld) chars[len[2:0]] <= dig_ascii;
                    if (done) begin
                        if (EOL_EN) begin
                            chars[base[2:0]]        <= ASC_CR;
                            chars[base[2:0] + 3'd1] <= ASC_LF;
                            len <= base + 4'd2;
                        end else begin
                            len <= base;
                        end
                        valid_q <= 1'b1;
                        tx_q    <= first_ch;
                        state   <= S_SEND;
                    end else begin
                        len <= base;
                    end
                end
                S_SEND: begin
                    tick_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tick_cnt == FT) state <= S_GAP;
                    else if (bus.txen) tick_cnt <= tick_cnt + 4'd1;
                end
                S_GAP: begin
                    if (idx_nx == len) begin
                        idx   <= '0;
                        state <= S_IDLE;
                    end else begin
                        idx     <= idx_nx;
                        valid_q <= 1'b1;
                        tx_q    <= chars[idx_nx[2:0]];
                        state   <= S_SEND;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.res_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.valid     = valid_q;
    assign bus.tx_data   = tx_q;

endmodule

// File: doc/uart_result_fmt.md
# uart_result_fmt

Upstream companion of the UART transmitter in the calculator datapath. Accepts one signed 16-bit calculator result (or an error flag) and converts it to decimal ASCII: optional '-', digits with leading zeros suppressed, then CR LF. It then presents the characters one at a time on the transmitter's `valid`/`tx_data` inputs. Because the transmitter has no ready output, frame pacing comes from counting the shared baud tick `txen`.

## Interface

Parameters:
- `FRAME_TICKS`, 11: `txen` ticks from a `valid` pulse until the transmitter is back in IDLE (start + 8 data + stop + return).
- `EOL_EN`, 1: when 1, append 0x0D 0x0A after every result; when 0, send no terminator.

Ports:
- `clk`, in, 1: the single clock.
- `n_rst`, in, 1: asynchronous, active-low reset.
- `res_valid`, in, 1: result strobe; accepted only while `res_ready`=1.
- `res_data`, in, 16: result, two's complement.
- `res_err`, in, 1: sampled with `res_valid`; 1 means send "ERR" and ignore `res_data`.
- `res_ready`, out, 1: high only in IDLE.
- `txen`, in, 1: one-cycle baud tick, the same signal that drives the transmitter.
- `tx_data`, out, 8: character to the transmitter.
- `valid`, out, 1: one-cycle start pulse to the transmitter.
- `busy`, out, 1: equals `!res_ready`.

## Operation

States: IDLE, CONV, SEND, WAIT, GAP.

- **IDLE**
  - Stay here until `res_valid`=1.
  - On accept, capture `neg = res_data[15] & !res_err` and `mag = neg ? -res_data : res_data`, as 16-bit unsigned. -32768 gives 32768.
  - Clear the character buffer (8 entries x 8 bits) and set `len`=0.
  - If `res_err`=1, load 'E' 'R' 'R' (0x45 0x52 0x52) and go to SEND. Otherwise, if `neg`, push '-' (0x2D), then go to CONV.
- **CONV**
  - Repeated subtraction over weights 10000, 1000, 100, 10, 1, indexed `k`=0..4.
  - Each cycle:
    - If `mag >= weight[k]`: subtract `weight[k]` and increment `digit`.
    - Otherwise: emit `digit` as 0x30+digit, unless it is zero and no nonzero digit has been emitted yet and `k`<4. Then clear `digit` and increment `k`.
  - The `k`=4 digit is always emitted, so zero prints "0".
  - After `k`=4, go to SEND. Worst case is 50 cycles.
- **Terminator.** When `EOL_EN`=1, 0x0D and 0x0A are appended when entering SEND. Maximum `len` is 8 ("-32768\r\n").
- **SEND**
  - One cycle with `valid`=1 and `tx_data` = `buf[idx]`.
  - Go to WAIT with `tick_cnt`=0.
- **WAIT**
  - Hold `tx_data` stable. Increment `tick_cnt` on each `txen`.
  - Go to GAP in the cycle after `tick_cnt` reaches `FRAME_TICKS`.
- **GAP**
  - One idle cycle, then `idx`++.
  - If `idx == len`: go to IDLE and clear `idx`. Otherwise go to SEND.

## Timing

- Reset values:
  - outputs: `valid`=0, `tx_data`=0x00, `res_ready`=1, `busy`=0;
  - internals: state IDLE, `idx`/`len`/`tick_cnt`/`digit`/`k` all 0.
- `res_ready` depends on state only; it does not combinationally depend on `res_valid`.
- Acceptance: the `res_valid` cycle is edge T. CONV starts at T+1.
- `valid` is registered and never high for two consecutive cycles.
- Pulse spacing: consecutive `valid` pulses are separated by exactly `FRAME_TICKS` `txen` ticks plus 2 cycles. The extra cycles are the WAIT exit and GAP.
- `txen` in the same cycle as the `valid` pulse is not counted. Counting starts the cycle after SEND, when the transmitter is in START.
- `tx_data` does not change from the SEND cycle through the end of WAIT. The transmitter latches on its first START tick.
- `res_valid` while busy is ignored, and the result is lost. Upstream must honour `res_ready`.
- Asynchronous reset mid-frame forces all reset values immediately. The formatter must be reset together with the transmitter.
- Arithmetic:
  - `mag` is 16-bit unsigned; the subtract compare is unsigned.
  - `digit` is 4 bits and never exceeds 9.
  - `tick_cnt` is 4 bits.

## Structure

- Shared package: state encoding; ASCII constants ('-', '0', 'E', 'R', CR, LF); the weight table 10000/1000/100/10/1; the `FRAME_TICKS` default of 11.
- Sub-module `bin2dec_seq`: the repeated-subtraction converter.
  - Inputs: `start`, `mag[15:0]`.
  - Outputs: per-digit strobe with ASCII byte, plus `done`.
  - Leading-zero suppression sits inside the sub-module.
- The top level holds the FSM, the character buffer and the tick counter.

## Test plan

- `res_data`=123, `txen` every 16 cycles -> `valid` pulses with 0x31 0x32 0x33 0x0D 0x0A; every gap is exactly 11 ticks + 2 cycles. Check against the transmitter model: `txd` idles high between frames.
- `res_data`=0x8000 (-32768) -> 0x2D 0x33 0x32 0x37 0x36 0x38 0x0D 0x0A; `len`=8; no buffer overflow.
- `res_data`=0 -> 0x30 0x0D 0x0A. `res_data`=0xFFFF (-1) -> 0x2D 0x31 0x0D 0x0A.
- `res_err`=1 with `res_data`=0x1234 -> 0x45 0x52 0x52 0x0D 0x0A. With `EOL_EN`=0 -> 0x45 0x52 0x52 only.
- Second `res_valid` during WAIT -> ignored, `res_ready`=0. A new `res_valid` in the cycle `res_ready` returns to 1 is accepted.
- `n_rst` low midway through WAIT of the 2nd character -> `valid`=0, `tx_data`=0x00, `res_ready`=1. After release, the next result is formatted from its first character.
